// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the dmem MMIO responder: register offsets and STATUS bit positions.
package dmem_mmio_pkg;

  localparam logic [3:0] OFF_CYCLE   = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h1;
  localparam logic [3:0] OFF_TXDATA  = 4'h2;
  localparam logic [3:0] OFF_SCRATCH = 4'h3;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Registered-storage FIFO with no fall-through. A push while full is still accepted when a pop
// happens on the same edge; otherwise it is dropped and reported by a one-cycle overflow pulse.
module sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop, push_ok;

  // Handshake qualification and occupancy update.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop      = pop_req & ~empty;
    push_ok  = push & (~full | pop);
    overflow = push & ~push_ok;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // Storage, pointers and count; reset flushes everything including the head word.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Sits between the processor dmem port and the dmem syncram. The top 16 words of the address
// space are MMIO (cycle counter, status, FIFO push port, scratch); everything else passes through.
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned         ADDR_W     = 12,
  parameter int unsigned         DATA_W     = 32,
  parameter logic [ADDR_W-1:0]   MMIO_BASE  = 12'hFF0,
  parameter int unsigned         FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              is_mmio, mmio_wr;
  logic [3:0]        offset;
  logic [DATA_W-1:0] cycle_q, cycle_d, scratch_q, status, rdata;
  logic [DATA_W-1:0] mmio_rdata_q;
  logic              sel_q, overflow_q;
  logic              fifo_full, fifo_empty, fifo_ovf, tx_push;
  logic [CNT_W-1:0]  fifo_count;
  logic [4:0]        count5;

  // Window decode and dmem passthrough; MMIO stores are kept away from dmem.
  always_comb begin
    is_mmio     = (cpu_address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
    offset      = cpu_address[3:0];
    mmio_wr     = cpu_wren & is_mmio;
    tx_push     = mmio_wr & (offset == OFF_TXDATA);
    mem_address = cpu_address;
    mem_data    = cpu_data;
    mem_wren    = cpu_wren & ~is_mmio;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (cpu_data),
    .pop_req   (out_ready),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  assign out_valid = ~fifo_empty;

  // STATUS word assembly and MMIO read decode (value as seen before the edge).
  always_comb begin
    count5                    = 5'(fifo_count);
    status                    = '0;
    status[ST_EMPTY]          = fifo_empty;
    status[ST_FULL]           = fifo_full;
    status[ST_OVF]            = overflow_q;
    status[ST_CNT_LSB +: 5]   = count5;
    case (offset)
      OFF_CYCLE:   rdata = cycle_q;
      OFF_STATUS:  rdata = status;
      OFF_SCRATCH: rdata = scratch_q;
      default:     rdata = '0;
    endcase
    // A store to CYCLE replaces that edge's increment.
    cycle_d = (mmio_wr && offset == OFF_CYCLE) ? cpu_data : cycle_q + DATA_W'(1);
  end

  // Register state: counter, scratch, sticky overflow and the one-cycle read pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q      <= '0;
      scratch_q    <= '0;
      overflow_q   <= 1'b0;
      sel_q        <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      if (mmio_wr && offset == OFF_SCRATCH) scratch_q <= cpu_data;
      if (fifo_ovf) overflow_q <= 1'b1;
      else if (mmio_wr && offset == OFF_STATUS) overflow_q <= 1'b0;
      sel_q        <= is_mmio;
      mmio_rdata_q <= rdata;
    end
  end

  assign cpu_q = sel_q ? mmio_rdata_q : mem_q;

endmodule
